stream_kernel3x3: RTL and testbench

// Streaming 3x3 neighbourhood filter for greyscale video. Replaces per-window filtering with

---
 rtl/stream_kernel3x3_if.sv | 10 +
 rtl/stream_kernel3x3.sv | 141 ++++++++++++++
 tb/tb_stream_kernel3x3.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_kernel3x3_if.sv
// stream_kernel3x3_if: valid/ready pixel stream with start/end-of-frame markers.
interface stream_kernel3x3_if #(parameter int DATA_W = 8);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic              sof;
    logic              eof;
    modport master(output valid, data, sof, eof, input ready);
    modport slave(input valid, data, sof, eof, output ready);
endinterface

// File: rtl/stream_kernel3x3.sv
// stream_kernel3x3: raster-order 3x3 neighbourhood filter (edge, blur, sharpen, pass)
// with internal line buffers and a two-stage valid/ready pipeline.
module stream_kernel3x3 #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         mode,
    input  logic [DATA_W-1:0]  threshold,
    stream_kernel3x3_if.slave  s,
    stream_kernel3x3_if.master m,
    output logic               frame_err
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int GW = DATA_W + 2;
    localparam int SW = DATA_W + 6;
    localparam logic [DATA_W-1:0] MAXV = '1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_q;
    logic [CW-1:0]     col_q;
    logic [RW-1:0]     row_q;
    logic [1:0]        mode_q;
    logic [DATA_W-1:0] thr_q;
    logic              ok_q, sof1_q, eof1_q;
    logic              m_valid_q, m_sof_q, m_eof_q, err_q;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic [DATA_W-1:0] w_q   [9];
    logic [DATA_W-1:0] lb1_q [IMG_W];
    logic [DATA_W-1:0] lb2_q [IMG_W];

    logic          adv, acc, proc_en, last;
    logic [CW-1:0] pc;
    logic [RW-1:0] pr;

    assign adv       = ~m_valid_q | m.ready;
    assign acc       = s.valid & adv;
    assign proc_en   = acc & (s.sof | (state_q == RUN));
    assign pc        = s.sof ? '0 : col_q;
    assign pr        = s.sof ? '0 : row_q;
    assign last      = (pr == RW'(IMG_H - 1)) && (pc == CW'(IMG_W - 1));
    assign s.ready   = adv;
    assign m.valid   = m_valid_q;
    assign m.data    = m_data_q;
    assign m.sof     = m_sof_q;
    assign m.eof     = m_eof_q;
    assign frame_err = err_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q   <= IDLE;
            col_q     <= '0;
            row_q     <= '0;
            mode_q    <= '0;
            thr_q     <= '0;
            ok_q      <= 1'b0;
            sof1_q    <= 1'b0;
            eof1_q    <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_sof_q   <= 1'b0;
            m_eof_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            err_q <= acc & s.sof & (state_q == RUN);
            if (acc & s.sof) begin
                mode_q <= mode;
                thr_q  <= threshold;
            end
            if (proc_en) begin
                state_q <= last ? IDLE : RUN;
                col_q   <= (pc == CW'(IMG_W - 1)) ? '0 : pc + CW'(1);
                row_q   <= last ? '0 : (pc == CW'(IMG_W - 1)) ? pr + RW'(1) : pr;
            end
            // the S1 flags are refreshed on every advance, so a consumed window never repeats
            if (adv) begin
                ok_q      <= proc_en && (pr >= RW'(2)) && (pc >= CW'(2));
                sof1_q    <= proc_en && (pr == RW'(2)) && (pc == CW'(2));
                eof1_q    <= proc_en && last;
                m_valid_q <= ok_q;
                m_data_q  <= m_data_d;
                m_sof_q   <= sof1_q;
                m_eof_q   <= eof1_q;
            end
        end

    // window columns: newest at a3/a6/a9; line buffers are indexed by column
    always_ff @(posedge clk)
        if (proc_en) begin
            w_q[0]    <= w_q[1];
            w_q[1]    <= w_q[2];
            w_q[2]    <= lb2_q[pc];
            w_q[3]    <= w_q[4];
            w_q[4]    <= w_q[5];
            w_q[5]    <= lb1_q[pc];
            w_q[6]    <= w_q[7];
            w_q[7]    <= w_q[8];
            w_q[8]    <= s.data;
            lb1_q[pc] <= s.data;
            lb2_q[pc] <= lb1_q[pc];
        end

    function automatic logic [GW-1:0] tri3(input logic [DATA_W-1:0] x, y, z);
        return {2'b0, x} + {1'b0, y, 1'b0} + {2'b0, z};
    endfunction

    logic [GW-1:0]     gxa, gxb, gya, gyb, gx, gy;
    logic [2*GW-1:0]   gx2, gy2;
    logic [2*GW:0]     g, t2;
    logic [DATA_W+3:0] sum;
    logic [SW-1:0]     v, vq;
    logic [DATA_W-1:0] edge_px, blur_px, sharp_px;

    always_comb begin
        gxa      = tri3(w_q[0], w_q[3], w_q[6]);
        gxb      = tri3(w_q[2], w_q[5], w_q[8]);
        gya      = tri3(w_q[6], w_q[7], w_q[8]);
        gyb      = tri3(w_q[0], w_q[1], w_q[2]);
        gx       = (gxa > gxb) ? gxa - gxb : gxb - gxa;
        gy       = (gya > gyb) ? gya - gyb : gyb - gya;
        gx2      = {{GW{1'b0}}, gx} * {{GW{1'b0}}, gx};
        gy2      = {{GW{1'b0}}, gy} * {{GW{1'b0}}, gy};
        g        = {1'b0, gx2} + {1'b0, gy2};
        t2       = {{(2*GW+1-DATA_W){1'b0}}, thr_q} * {{(2*GW+1-DATA_W){1'b0}}, thr_q};
        sum      = '0;
        for (int i = 0; i < 9; i++) sum = sum + {4'b0, w_q[i]};
        // 17*a5 - (sum - a5); the sign bit survives the modular arithmetic
        v        = SW'(18) * {6'b0, w_q[4]} - {2'b0, sum};
        vq       = v / SW'(9);
        edge_px  = (g > t2) ? '0 : MAXV;
        blur_px  = DATA_W'(sum / (DATA_W+4)'(9));
        sharp_px = v[SW-1] ? '0 : (vq > SW'(MAXV)) ? MAXV : DATA_W'(vq);
        m_data_d = (mode_q == 2'd0) ? edge_px :
                   (mode_q == 2'd1) ? blur_px :
                   (mode_q == 2'd2) ? sharp_px : w_q[4];
    end
endmodule

// File: tb/tb_stream_kernel3x3.sv
// tb_stream_kernel3x3: directed table-driven bench for a 4x4 image plus
// hand-written latency, back-pressure, restart and reset sequences.
module tb_stream_kernel3x3;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [7:0] threshold = 8'd0;
    logic       frame_err;

    stream_kernel3x3_if #(.DATA_W(8)) s_if();
    stream_kernel3x3_if #(.DATA_W(8)) m_if();

    stream_kernel3x3 #(.DATA_W(8), .IMG_W(4), .IMG_H(4)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .threshold(threshold),
        .s(s_if), .m(m_if), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] md;
        logic [7:0] th;
        int         kind;
        int         e0, e1, e2, e3;
    } vec_t;

    vec_t       vecs[15];
    int         total = 0;
    int         passed = 0;
    int         err_cnt = 0;
    bit         rnd_ready = 0;
    logic [9:0] q[$];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    function automatic vec_t mk(input logic [1:0] md, input logic [7:0] th, input int kind,
                                input int a, input int b, input int c, input int d);
        vec_t v;
        v.md = md; v.th = th; v.kind = kind;
        v.e0 = a; v.e1 = b; v.e2 = c; v.e3 = d;
        return v;
    endfunction

    function automatic logic [7:0] pix_of(input int kind, input int i);
        int r;
        int c;
        r = i / 4;
        c = i % 4;
        case (kind)
            0: return 8'(i);
            1: return 8'd9;
            2: return 8'd255;
            3: return (c < 2) ? 8'd0 : 8'd100;
            4: return (c < 2) ? 8'd0 : 8'd1;
            5: return (r < 2) ? 8'd0 : 8'd1;
            6: return (i == 5) ? 8'd0 : 8'd255;
            7: return (i == 5) ? 8'd255 : 8'd0;
            8: return 8'd100;
            9: return (c == 3) ? 8'd8 : 8'd0;
            default: return 8'd0;
        endcase
    endfunction

    // downstream ready: always 1, or 50% random when rnd_ready is set
    initial begin
        m_if.ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_if.ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // output monitor: transfers happen at the posedge following a negedge with valid & ready
    initial begin
        logic        held = 1'b0;
        logic [10:0] hv = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) held = 1'b0;
            else begin
                if (held) chk("stall hold", int'({m_if.valid, m_if.data, m_if.sof, m_if.eof}), int'(hv));
                held = m_if.valid & ~m_if.ready;
                hv   = {m_if.valid, m_if.data, m_if.sof, m_if.eof};
                if (m_if.valid && m_if.ready) q.push_back({m_if.data, m_if.sof, m_if.eof});
                if (frame_err) err_cnt++;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
        $fatal(1);
    end

    task automatic send_px(input logic [7:0] v, input bit sf);
        bit ok = 0;
        s_if.valid = 1'b1;
        s_if.data  = v;
        s_if.sof   = sf;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (s_if.ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("s_ready timeout", 0, 1);
        @(posedge clk);
        #1;
        s_if.valid = 1'b0;
        s_if.sof   = 1'b0;
    endtask

    task automatic send_frame(input int kind, input logic [1:0] md, input logic [7:0] th, input bit gaps);
        for (int i = 0; i < 16; i++) begin
            if (gaps && $urandom_range(0, 1) == 1)
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk);
                    #1;
                end
            mode      = (i == 0) ? md : ~md;
            threshold = (i == 0) ? th : ~th;
            send_px(pix_of(kind, i), i == 0);
        end
    endtask

    task automatic expect_out(input string nm, input int d, input bit sf, input bit ef);
        logic [9:0] o;
        int k = 0;
        while (q.size() == 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (q.size() == 0) begin
            chk({nm, " timeout"}, 0, 1);
            return;
        end
        o = q.pop_front();
        chk({nm, " data"}, int'(o[9:2]), d);
        chk({nm, " sof/eof"}, int'(o[1:0]), int'({sf, ef}));
    endtask

    task automatic check_frame(input string nm, input vec_t v);
        expect_out({nm, " out0"}, v.e0, 1'b1, 1'b0);
        expect_out({nm, " out1"}, v.e1, 1'b0, 1'b0);
        expect_out({nm, " out2"}, v.e2, 1'b0, 1'b0);
        expect_out({nm, " out3"}, v.e3, 1'b0, 1'b1);
    endtask

    initial begin
        int e0;
        s_if.valid = 1'b0;
        s_if.data  = '0;
        s_if.sof   = 1'b0;
        s_if.eof   = 1'b0;
        vecs[0]  = mk(2'd3, 8'd0,  0, 5, 6, 9, 10);
        vecs[1]  = mk(2'd1, 8'd0,  1, 9, 9, 9, 9);
        vecs[2]  = mk(2'd1, 8'd0,  2, 255, 255, 255, 255);
        vecs[3]  = mk(2'd1, 8'd0,  9, 0, 2, 0, 2);
        vecs[4]  = mk(2'd1, 8'd0,  0, 5, 6, 9, 10);
        vecs[5]  = mk(2'd0, 8'd10, 3, 0, 0, 0, 0);
        vecs[6]  = mk(2'd0, 8'd10, 8, 255, 255, 255, 255);
        vecs[7]  = mk(2'd0, 8'd4,  4, 255, 255, 255, 255);
        vecs[8]  = mk(2'd0, 8'd3,  4, 0, 0, 0, 0);
        vecs[9]  = mk(2'd0, 8'd4,  5, 255, 255, 255, 255);
        vecs[10] = mk(2'd0, 8'd3,  5, 0, 0, 0, 0);
        vecs[11] = mk(2'd2, 8'd0,  6, 0, 255, 255, 255);
        vecs[12] = mk(2'd2, 8'd0,  7, 255, 0, 0, 0);
        vecs[13] = mk(2'd2, 8'd0,  8, 100, 100, 100, 100);
        vecs[14] = mk(2'd2, 8'd0,  0, 5, 6, 9, 10);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset m_valid", int'(m_if.valid), 0);
        chk("reset m_data", int'(m_if.data), 0);
        chk("reset m_sof", int'(m_if.sof), 0);
        chk("reset m_eof", int'(m_if.eof), 0);
        chk("reset frame_err", int'(frame_err), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("s_ready after reset", int'(s_if.ready), 1);

        for (int i = 0; i < 15; i++) begin
            send_frame(vecs[i].kind, vecs[i].md, vecs[i].th, 1'b0);
            check_frame($sformatf("vec%0d", i), vecs[i]);
        end

        // first output appears on the edge after the accepting edge
        mode = 2'd3;
        for (int i = 0; i < 10; i++) send_px(8'(i), i == 0);
        send_px(8'd10, 1'b0);
        chk("latency early m_valid", int'(m_if.valid), 0);
        @(posedge clk);
        #1;
        chk("latency m_valid", int'(m_if.valid), 1);
        chk("latency m_data", int'(m_if.data), 5);
        for (int i = 11; i < 16; i++) send_px(8'(i), 1'b0);
        check_frame("latency frame", vecs[0]);

        // three back-to-back frames with random gaps and random back-pressure
        rnd_ready = 1;
        send_frame(vecs[0].kind, vecs[0].md, vecs[0].th, 1'b1);
        send_frame(vecs[3].kind, vecs[3].md, vecs[3].th, 1'b1);
        send_frame(vecs[11].kind, vecs[11].md, vecs[11].th, 1'b1);
        check_frame("bp frame0", vecs[0]);
        check_frame("bp frame1", vecs[3]);
        check_frame("bp frame2", vecs[11]);
        rnd_ready = 0;
        repeat (3) @(posedge clk);
        #1;

        // restart mid-frame while an output is pending
        e0 = err_cnt;
        mode = 2'd3;
        for (int i = 0; i < 11; i++) send_px(8'(i), i == 0);
        send_frame(0, 2'd3, 8'd0, 1'b0);
        expect_out("pending before restart", 5, 1'b1, 1'b0);
        check_frame("after restart", vecs[0]);
        repeat (3) @(posedge clk);
        #1;
        chk("frame_err pulses", err_cnt - e0, 1);

        // reset mid-frame with an output just presented
        for (int i = 0; i < 11; i++) send_px(8'(i), i == 0);
        @(posedge clk);
        #1;
        chk("pre-reset m_valid", int'(m_if.valid), 1);
        rst_n = 1'b0;
        #1;
        chk("async reset m_valid", int'(m_if.valid), 0);
        chk("async reset m_eof", int'(m_if.eof), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) send_px(8'(i), 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("no output without sof", q.size(), 0);
        send_frame(0, 2'd3, 8'd0, 1'b0);
        check_frame("post-reset frame", vecs[0]);
        chk("no extra output", q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
